alu_exec_ctrl: RTL

- Multi-cycle sequencer for the register-file + ALU execute datapath.
- Accepts one 32-bit RV32I R-type or I-type ALU instruction through a valid/ready handshake.
- Decodes the instruction into rs1/rs2/rd/imm/opcode/Opsel, steps the datapath through read, execute and write-back, then returns the ALU result and zero flag.
- Flags illegal encodings and counts retired instructions; sits between the fetch stage and the execute datapath.

---
 rtl/alu_exec_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - multi-cycle sequencer for the register-file + ALU execute datapath
module alu_exec_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [11:0]      imm_in,
    output logic [6:0]       opcode,
    output logic [3:0]       Opsel,
    output logic             reg_write,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_zero,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_Z = 7'b0000000;
    localparam logic [6:0] F7_A = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        EXE  = 3'd2,
        WB   = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] opsel_dec;
    logic       legal;

    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Fields come straight from the latched word, so they hold until the next accept.
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign rd     = instr_q[11:7];
    assign imm_in = instr_q[31:20];
    assign opcode = instr_q[6:0];
    assign Opsel  = opsel_dec;

    always_comb begin
        opsel_dec = ALU_ADD;
        legal     = 1'b0;
        if (opcode == OP_R) begin
            unique case (funct3)
                3'b000: begin
                    if (funct7 == F7_Z) begin
                        opsel_dec = ALU_ADD;
                        legal     = 1'b1;
                    end else if (funct7 == F7_A) begin
                        opsel_dec = ALU_SUB;
                        legal     = 1'b1;
                    end
                end
                3'b001: begin opsel_dec = ALU_SLL;  legal = (funct7 == F7_Z); end
                3'b010: begin opsel_dec = ALU_SLT;  legal = (funct7 == F7_Z); end
                3'b011: begin opsel_dec = ALU_SLTU; legal = (funct7 == F7_Z); end
                3'b100: begin opsel_dec = ALU_XOR;  legal = (funct7 == F7_Z); end
                3'b101: begin
                    if (funct7 == F7_Z) begin
                        opsel_dec = ALU_SRL;
                        legal     = 1'b1;
                    end else if (funct7 == F7_A) begin
                        opsel_dec = ALU_SRA;
                        legal     = 1'b1;
                    end
                end
                3'b110: begin opsel_dec = ALU_OR;   legal = (funct7 == F7_Z); end
                3'b111: begin opsel_dec = ALU_AND;  legal = (funct7 == F7_Z); end
                default: legal = 1'b0;
            endcase
        end else if (opcode == OP_I) begin
            // Only the shift immediates constrain the upper immediate bits.
            unique case (funct3)
                3'b000: begin opsel_dec = ALU_ADD;  legal = 1'b1; end
                3'b001: begin opsel_dec = ALU_SLL;  legal = (funct7 == F7_Z); end
                3'b010: begin opsel_dec = ALU_SLT;  legal = 1'b1; end
                3'b011: begin opsel_dec = ALU_SLTU; legal = 1'b1; end
                3'b100: begin opsel_dec = ALU_XOR;  legal = 1'b1; end
                3'b101: begin
                    if (funct7 == F7_Z) begin
                        opsel_dec = ALU_SRL;
                        legal     = 1'b1;
                    end else if (funct7 == F7_A) begin
                        opsel_dec = ALU_SRA;
                        legal     = 1'b1;
                    end
                end
                3'b110: begin opsel_dec = ALU_OR;   legal = 1'b1; end
                3'b111: begin opsel_dec = ALU_AND;  legal = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (instr_valid) state_d = DEC;
            DEC:     state_d = legal ? EXE : IDLE;
            EXE:     state_d = WB;
            WB:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == DEC) && !legal;
            if (state_q == IDLE && instr_valid) begin
                instr_q <= instr;
            end
            // Result, flag and count all become visible together with done.
            if (state_q == WB) begin
                result_q  <= alu_out;
                zero_q    <= alu_zero;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign reg_write   = (state_q == WB) && (rd != 5'd0);
    assign done        = (state_q == RSP);
    assign result      = result_q;
    assign zero        = zero_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule
